instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Upstream fetch stage for the 32-bit MIPS-subset datapath. Holds the PC and fetches from instruction memory over a variable-latency req/ready handshake. Latches the instruction and presents decoded fields (op, func, rs, rt, rd, shamt, imm) to the controller. On commit it selects the next PC from the controller's PCSrc: PC+4 or the bne target.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, PC / instruction-memory address width

Ports:
Clk  input  1  system clock; all state updates on rising edge
Rst  input  1  synchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  ADDR_W  byte address of the fetch (equals PC)
imem_rdata  input  32  instruction word; valid when imem_ready=1
imem_ready  input  1  memory response strobe; meaningful only while imem_req=1
instr_valid  output  1  instruction register holds a fetched, uncommitted instruction
instr_ack  input  1  downstream commits the current instruction this cycle
PCSrc  input  1  from controller; sampled only when instr_valid & instr_ack
op  output  6  instr[31:26]
rs  output  5  instr[25:21]
rt  output  5  instr[20:16]
rd  output  5  instr[15:11]
shamt  output  5  instr[10:6]
func  output  6  instr[5:0]
imm  output  16  instr[15:0]
pc  output  ADDR_W  address of the instruction in the register
pc_plus4  output  ADDR_W  pc + 4

Behaviour:
- Reset (Rst=1 at an edge): state=IDLE, PC=RESET_PC, instruction register=32'h0, imem_req=0, instr_valid=0. All decoded fields are 0. Reset overrides every other input, including in-flight fetches.
- FSM states: IDLE, REQ, WAIT, VALID.
  - IDLE: imem_req=0. Next state is REQ unconditionally, so the first request comes 1 cycle after reset deasserts.
  - REQ and WAIT: imem_req=1, imem_addr=PC.
    - If imem_ready=1, imem_rdata is captured into the instruction register and the next state is VALID.
    - Otherwise REQ goes to WAIT, and WAIT stays in WAIT.
    - The request and address stay stable until ready.
    - Minimum latency is PC applied to instr_valid=1 in 1 cycle (ready in the REQ cycle).
  - VALID: instr_valid=1 and imem_req=0. Fields are held stable until ack.
    - On instr_ack=1: PC <= PCSrc ? branch_target : pc_plus4, then the next state is REQ. Back-to-back fetch gives 2 cycles per instruction at zero memory wait.
    - instr_ack=0: hold.
- Arithmetic:
  - branch_target = pc_plus4 + ({{14{imm[15]}}, imm, 2'b00}), computed in ADDR_W bits.
  - pc_plus4 = pc + 4 modulo 2^ADDR_W, so 32'hFFFF_FFFC wraps to 0.
  - No overflow flag.
- Boundary rules:
  - instr_ack outside VALID is ignored.
  - PCSrc is ignored unless the ack is accepted.
  - imem_ready outside REQ/WAIT is ignored.
  - imem_addr[1:0] is always 2'b00. PC bits [1:0] are forced to 0 on every load, including RESET_PC.
  - A memory response arriving in the same cycle as Rst=1 is discarded.
- Outputs are all registered or direct slices of registers. There is no combinational path from inputs to outputs.

Optional Feature:
Macro IF_PERF_COUNT_EN.
- Defined: adds outputs cyc_count[31:0] and instr_count[31:0], both cleared by Rst.
  - cyc_count increments every non-reset cycle.
  - instr_count increments on each accepted ack.
  - Both wrap at 2^32.
- Undefined: these ports and registers do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package `mips_pkg` holds:
  - FSM state enum `if_state_t` (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, VALID=2'd3);
  - opcode constants OP_RTYPE=6'b000000, OP_BNE=6'b000101, OP_LW=6'b100011, OP_SW=6'b101011;
  - localparam INSTR_W=32.
- One natural sub-module: `branch_target_calc`, a combinational unit computing pc_plus4 and branch_target from pc and imm.

Test Plan:
- Reset: assert Rst 2 cycles with RESET_PC=32'h0000_0040 -> imem_req=0 and instr_valid=0 during reset. The cycle after deassert is IDLE; the next cycle has imem_req=1 and imem_addr=32'h40.
- Zero-wait fetch: ready=1 in REQ with rdata=32'h012A4020 (add $t0,$t1,$t2) -> next cycle instr_valid=1, op=0, rs=9, rt=10, rd=8, func=6'h20. Ack with PCSrc=0 -> next request at addr 32'h44.
- Wait states: hold ready=0 for 3 cycles -> imem_req and imem_addr stable in WAIT with instr_valid=0. Ready on the 4th cycle -> instr_valid=1 the cycle after.
- Branch taken: pc=32'h100, imm=16'hFFFE, ack with PCSrc=1 -> next imem_addr=32'h0FC. With imm=16'h0003 -> 32'h110.
- Ack stall: hold instr_ack=0 for 5 cycles in VALID and toggle PCSrc -> fields and pc unchanged, and no new request.
- Mid-fetch reset and wrap: assert Rst while in WAIT with ready=1 -> PC=RESET_PC, instr_valid stays 0. With pc=32'hFFFF_FFFC, ack with PCSrc=0 -> next imem_addr=32'h0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS-subset datapath.
// Rev 1.0
`default_nettype none

package mips_pkg;

   localparam int INSTR_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WAIT  = 2'd2,
      VALID = 2'd3
   } if_state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

endpackage

`default_nettype wire

// File: rtl/branch_target_calc.sv
// branch_target_calc: combinational pc+4 and bne target (pc+4 + sext(imm)<<2).
// Rev 1.0
`default_nettype none

module branch_target_calc #(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] i_pc,
   input  logic [15:0]       i_imm,
   output logic [ADDR_W-1:0] o_pc_plus4,
   output logic [ADDR_W-1:0] o_branch_target
);

   logic [ADDR_W-1:0] w_offset;

   assign w_offset        = {{(ADDR_W-18){i_imm[15]}}, i_imm, 2'b00};
   assign o_pc_plus4      = i_pc + ADDR_W'(4);
   assign o_branch_target = o_pc_plus4 + w_offset;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC + instruction fetch over req/ready, field decode, next-PC select.
// Optional macro IF_PERF_COUNT_EN adds cyc_count / instr_count. Rev 1.0
`default_nettype none

module instr_fetch_unit
   import mips_pkg::*;
#(
   parameter int              ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              Clk,
   input  logic              Rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              imem_ready,
   output logic              instr_valid,
   input  logic              instr_ack,
   input  logic              PCSrc,
   output logic [5:0]        op,
   output logic [4:0]        rs,
   output logic [4:0]        rt,
   output logic [4:0]        rd,
   output logic [4:0]        shamt,
   output logic [5:0]        func,
   output logic [15:0]       imm,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4
`ifdef IF_PERF_COUNT_EN
   ,
   output logic [31:0]       cyc_count,
   output logic [31:0]       instr_count
`endif
);

   localparam logic [ADDR_W-1:0] c_RESET_PC_ALIGNED = {RESET_PC[ADDR_W-1:2], 2'b00};

   if_state_t          r_state;
   if_state_t          w_state_nxt;
   logic [ADDR_W-1:0]  r_pc;
   logic [INSTR_W-1:0] r_instr;
   logic               r_req;
   logic               r_valid;
   logic [ADDR_W-1:0]  w_pc_plus4;
   logic [ADDR_W-1:0]  w_branch_target;
   logic [ADDR_W-1:0]  w_pc_sel;
   logic               w_fetch_done;
   logic               w_ack;

   branch_target_calc #(
      .ADDR_W (ADDR_W)
   ) u_btc (
      .i_pc            (r_pc),
      .i_imm           (r_instr[15:0]),
      .o_pc_plus4      (w_pc_plus4),
      .o_branch_target (w_branch_target)
   );

   // r_req / r_valid mirror the state so handshake outputs come straight from flops
   assign w_fetch_done = r_req & imem_ready;
   assign w_ack        = r_valid & instr_ack;
   assign w_pc_sel     = PCSrc ? w_branch_target : w_pc_plus4;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:     w_state_nxt = REQ;
         REQ:      w_state_nxt = imem_ready ? VALID : WAIT;
         WAIT:     w_state_nxt = imem_ready ? VALID : WAIT;
         VALID:    w_state_nxt = instr_ack  ? REQ   : VALID;
         default:  w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state <= IDLE;
         r_pc    <= c_RESET_PC_ALIGNED;
         r_instr <= '0;
         r_req   <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_req   <= (w_state_nxt == REQ) || (w_state_nxt == WAIT);
         r_valid <= (w_state_nxt == VALID);
         if (w_fetch_done) begin
            r_instr <= imem_rdata;
         end
         if (w_ack) begin
            r_pc <= {w_pc_sel[ADDR_W-1:2], 2'b00};
         end
      end
   end

`ifdef IF_PERF_COUNT_EN
   logic [31:0] r_cyc_count;
   logic [31:0] r_instr_count;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_cyc_count   <= '0;
         r_instr_count <= '0;
      end else begin
         r_cyc_count <= r_cyc_count + 32'd1;
         if (w_ack) begin
            r_instr_count <= r_instr_count + 32'd1;
         end
      end
   end

   assign cyc_count   = r_cyc_count;
   assign instr_count = r_instr_count;
`endif

   assign imem_req    = r_req;
   assign imem_addr   = r_pc;
   assign instr_valid = r_valid;
   assign pc          = r_pc;
   assign pc_plus4    = w_pc_plus4;
   assign op          = r_instr[31:26];
   assign rs          = r_instr[25:21];
   assign rt          = r_instr[20:16];
   assign rd          = r_instr[15:11];
   assign shamt       = r_instr[10:6];
   assign func        = r_instr[5:0];
   assign imm         = r_instr[15:0];

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed + randomized checks against an abstract fetch/PC model.
// Rev 1.0
`default_nettype none

module tb_instr_fetch_unit;
   import mips_pkg::*;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        imem_ready = 1'b0;
   logic        instr_valid;
   logic        instr_ack = 1'b0;
   logic        PCSrc = 1'b0;
   logic [5:0]  op;
   logic [4:0]  rs, rt, rd, shamt;
   logic [5:0]  func;
   logic [15:0] imm;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
`ifdef IF_PERF_COUNT_EN
   logic [31:0] cyc_count;
   logic [31:0] instr_count;
`endif

   int          total = 0;
   int          bad   = 0;
   logic [31:0] m_pc;
   logic [31:0] m_instr;

   instr_fetch_unit #(
      .ADDR_W   (32),
      .RESET_PC (32'h0000_0040)
   ) dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_ready  (imem_ready),
      .instr_valid (instr_valid),
      .instr_ack   (instr_ack),
      .PCSrc       (PCSrc),
      .op          (op),
      .rs          (rs),
      .rt          (rt),
      .rd          (rd),
      .shamt       (shamt),
      .func        (func),
      .imm         (imm),
      .pc          (pc),
      .pc_plus4    (pc_plus4)
`ifdef IF_PERF_COUNT_EN
      ,
      .cyc_count   (cyc_count),
      .instr_count (instr_count)
`endif
   );

   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Entered in a REQ cycle; waits cycles of ready=0 then one ready=1.
   task automatic do_fetch(input logic [31:0] word, input int waits);
      for (int i = 0; i <= waits; i++) begin
         total++;
         if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL fetch_req got req=%b addr=%h valid=%b exp req=1 addr=%h valid=0",
                     imem_req, imem_addr, instr_valid, m_pc);
         end
         imem_ready = (i == waits);
         imem_rdata = (i == waits) ? word : $urandom;
         instr_ack  = 1'($urandom_range(0, 1));
         PCSrc      = 1'($urandom_range(0, 1));
         step();
      end
      imem_ready = 1'b0;
      instr_ack  = 1'b0;
      m_instr    = word;
      total++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 ||
          {op, rs, rt, rd, shamt, func} !== m_instr || imm !== m_instr[15:0] ||
          pc !== m_pc || pc_plus4 !== m_pc + 32'd4) begin
         bad++;
         $display("FAIL fetch_valid got valid=%b req=%b instr=%h pc=%h pc4=%h exp instr=%h pc=%h",
                  instr_valid, imem_req, {op, rs, rt, rd, shamt, func}, pc, pc_plus4, m_instr, m_pc);
      end
   endtask

   // Entered in a VALID cycle; stalls, then acks and checks the next request address.
   task automatic do_ack(input logic pcsrc, input int stall);
      int off;
      for (int i = 0; i < stall; i++) begin
         instr_ack  = 1'b0;
         PCSrc      = 1'($urandom_range(0, 1));
         imem_ready = 1'($urandom_range(0, 1));
         imem_rdata = $urandom;
         step();
         total++;
         if (instr_valid !== 1'b1 || imem_req !== 1'b0 ||
             {op, rs, rt, rd, shamt, func} !== m_instr || pc !== m_pc) begin
            bad++;
            $display("FAIL ack_stall got valid=%b req=%b instr=%h pc=%h exp instr=%h pc=%h",
                     instr_valid, imem_req, {op, rs, rt, rd, shamt, func}, pc, m_instr, m_pc);
         end
      end
      imem_ready = 1'b0;
      instr_ack  = 1'b1;
      PCSrc      = pcsrc;
      step();
      instr_ack  = 1'b0;
      off  = 4 * int'($signed(m_instr[15:0]));
      m_pc = pcsrc ? (m_pc + 32'd4 + 32'(off)) : (m_pc + 32'd4);
      total++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0) begin
         bad++;
         $display("FAIL ack_next got req=%b addr=%h valid=%b exp req=1 addr=%h valid=0",
                  imem_req, imem_addr, instr_valid, m_pc);
      end
   endtask

   task automatic goto_pc(input logic [31:0] target);
      logic [31:0] d;
      d = target - (m_pc + 32'd4);
      do_fetch({OP_BNE, 5'd1, 5'd2, d[17:2]}, 0);
      do_ack(1'b1, 0);
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      imem_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         total++;
         if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h40 ||
             {op, rs, rt, rd, shamt, func} !== 32'h0) begin
            bad++;
            $display("FAIL reset_state got req=%b valid=%b pc=%h instr=%h exp 0 0 00000040 0",
                     imem_req, instr_valid, pc, {op, rs, rt, rd, shamt, func});
         end
      end
      Rst = 1'b0;
      imem_ready = 1'b0;
      step();
      m_pc = 32'h40;
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
         bad++;
         $display("FAIL reset_first_req got req=%b addr=%h exp 1 00000040", imem_req, imem_addr);
      end
   endtask

   task automatic test_zero_wait();
      do_fetch(32'h012A4020, 0);
      total++;
      if (op !== 6'd0 || rs !== 5'd9 || rt !== 5'd10 || rd !== 5'd8 || func !== 6'h20) begin
         bad++;
         $display("FAIL zero_wait_fields got op=%h rs=%0d rt=%0d rd=%0d func=%h exp 0 9 10 8 20",
                  op, rs, rt, rd, func);
      end
      do_ack(1'b0, 0);
      total++;
      if (imem_addr !== 32'h44) begin
         bad++;
         $display("FAIL zero_wait_next got addr=%h exp 00000044", imem_addr);
      end
   endtask

   task automatic test_wait_states();
      do_fetch($urandom, 3);
      do_ack(1'b0, 0);
   endtask

   task automatic test_branch();
      goto_pc(32'h100);
      do_fetch({OP_BNE, 5'd3, 5'd4, 16'hFFFE}, 0);
      do_ack(1'b1, 0);
      total++;
      if (imem_addr !== 32'h0FC) begin
         bad++;
         $display("FAIL branch_back got addr=%h exp 000000fc", imem_addr);
      end
      goto_pc(32'h100);
      do_fetch({OP_BNE, 5'd3, 5'd4, 16'h0003}, 0);
      do_ack(1'b1, 0);
      total++;
      if (imem_addr !== 32'h110) begin
         bad++;
         $display("FAIL branch_fwd got addr=%h exp 00000110", imem_addr);
      end
   endtask

   task automatic test_ack_stall();
      do_fetch($urandom, 1);
      do_ack(1'($urandom_range(0, 1)), 5);
   endtask

   task automatic test_mid_reset_wrap();
      imem_ready = 1'b0;
      step();
      total++;
      if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_wait got req=%b valid=%b exp 1 0", imem_req, instr_valid);
      end
      Rst        = 1'b1;
      imem_ready = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      step();
      Rst        = 1'b0;
      imem_ready = 1'b0;
      total++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b0 || pc !== 32'h40 ||
          {op, rs, rt, rd, shamt, func} !== 32'h0) begin
         bad++;
         $display("FAIL mid_reset got valid=%b req=%b pc=%h instr=%h exp 0 0 00000040 0",
                  instr_valid, imem_req, pc, {op, rs, rt, rd, shamt, func});
      end
      step();
      m_pc = 32'h40;
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h40 || instr_valid !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_req got req=%b addr=%h valid=%b exp 1 00000040 0",
                  imem_req, imem_addr, instr_valid);
      end
      goto_pc(32'hFFFF_FFFC);
      do_fetch($urandom, 0);
      do_ack(1'b0, 0);
      total++;
      if (imem_addr !== 32'h0) begin
         bad++;
         $display("FAIL wrap got addr=%h exp 00000000", imem_addr);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         do_fetch($urandom, $urandom_range(0, 3));
         do_ack(1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end
   endtask

   initial begin
      m_pc    = 32'h40;
      m_instr = 32'h0;
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_branch();
      test_ack_stall();
      test_mid_reset_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
